// File: rtl/datapath_pkg.sv
// datapath_pkg
// Shared constants for the single-cycle R-type datapath: instruction field
// widths, the R-type opcode, the supported funct codes and the ALU control
// encoding.
package datapath_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam int OPCODE_W   = 6;
    localparam int SHAMT_W    = 5;
    localparam int FUNCT_W    = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'h27;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_t;

endpackage

// File: rtl/data_path_register_bank.sv
// register_bank
// 32 x 32-bit register file with two asynchronous read ports and one
// synchronous write port. Register 0 always reads as zero and ignores writes.
// Storage is deliberately named MEM so simulation can preload it by path.
// Ports:
//   clk      - rising-edge write clock
//   rs_addr  - read port A index
//   rt_addr  - read port B index
//   rd_addr  - write index
//   wr_en    - write strobe, sampled on the rising edge
//   wr_data  - write data
//   rs_data  - read port A data
//   rt_data  - read port B data
module register_bank
    import datapath_pkg::*;
(
    input  logic                  clk,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data
);

    reg [31:0] MEM [0:31];

    // No reset on the array so preloaded contents survive a datapath reset.
    always_ff @(posedge clk) begin
        if (wr_en && (rd_addr != '0)) begin
            MEM[rd_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge value during a write cycle.
    assign rs_data = (rs_addr == '0) ? '0 : MEM[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : MEM[rt_addr];

endmodule

// File: rtl/data_path.sv
// data_path
// Single-cycle MIPS-style R-type execution core: decodes the instruction,
// reads rs/rt from the register bank, computes the ALU result and writes it
// back to rd on the next rising edge.
// Ports:
//   clk         - clock, rising-edge active
//   reset       - synchronous active-high; clears wb_data/wb_valid only
//   instruction - R-type instruction word
//   alu_result  - combinational ALU result (0 for a NOP)
//   zero        - combinational, high when alu_result is 0
//   wb_data     - value of the most recent write-back
//   wb_valid    - high for the cycle following a write-back
module data_path
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] wb_data,
    output logic        wb_valid
);

    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [SHAMT_W-1:0]    unused_shamt;
    logic [FUNCT_W-1:0]    funct;

    logic                  instr_valid;
    alu_ctrl_t             alu_ctrl;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic                  wr_en;

    assign opcode       = instruction[31:26];
    assign rs           = instruction[25:21];
    assign rt           = instruction[20:16];
    assign rd           = instruction[15:11];
    assign unused_shamt = instruction[10:6];
    assign funct        = instruction[5:0];

    // Funct decode: anything other than a supported R-type op is a NOP.
    always_comb begin
        instr_valid = 1'b0;
        alu_ctrl    = ALU_AND;
        if (opcode == OP_RTYPE) begin
            instr_valid = 1'b1;
            case (funct)
                FUNCT_ADD: alu_ctrl = ALU_ADD;
                FUNCT_SUB: alu_ctrl = ALU_SUB;
                FUNCT_AND: alu_ctrl = ALU_AND;
                FUNCT_OR:  alu_ctrl = ALU_OR;
                FUNCT_NOR: alu_ctrl = ALU_NOR;
                FUNCT_SLT: alu_ctrl = ALU_SLT;
                default:   instr_valid = 1'b0;
            endcase
        end
    end

    register_bank RB (
        .clk     (clk),
        .rs_addr (rs),
        .rt_addr (rt),
        .rd_addr (rd),
        .wr_en   (wr_en),
        .wr_data (alu_result),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

    // ALU: arithmetic wraps silently; SLT is a signed compare.
    always_comb begin
        alu_result = '0;
        if (instr_valid) begin
            case (alu_ctrl)
                ALU_ADD: alu_result = rs_data + rt_data;
                ALU_SUB: alu_result = rs_data - rt_data;
                ALU_AND: alu_result = rs_data & rt_data;
                ALU_OR:  alu_result = rs_data | rt_data;
                ALU_NOR: alu_result = ~(rs_data | rt_data);
                ALU_SLT: alu_result = {31'b0, ($signed(rs_data) < $signed(rt_data))};
                default: alu_result = '0;
            endcase
        end
    end

    assign zero  = (alu_result == '0);

    // A reset in the same cycle suppresses the write.
    assign wr_en = instr_valid && (rd != '0) && !reset;

    // Write-back status; wb_data holds the last written value between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data  <= '0;
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= wr_en;
            if (wr_en) begin
                wb_data <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path
// Directed self-checking bench for data_path. Inputs change on the falling
// edge; combinational outputs are checked shortly after, registered outputs
// and register contents #1 after the rising edge.
module tb_data_path;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] wb_data;
    logic        wb_valid;

    int total = 0;
    int bad   = 0;

    data_path dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .alu_result  (alu_result),
        .zero        (zero),
        .wb_data     (wb_data),
        .wb_valid    (wb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Assemble an R-type word: opcode 0, shamt 0.
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a new instruction after the falling edge and let it settle.
    task automatic applyStimulus(input logic [31:0] instr);
        @(negedge clk);
        instruction = instr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] starting data_path bench");
        reset       = 1'b1;
        instruction = 32'h0;

        dut.RB.MEM[1]  = 32'd5;
        dut.RB.MEM[2]  = 32'd3;
        dut.RB.MEM[6]  = 32'hF0F0F0F0;
        dut.RB.MEM[7]  = 32'h0FF00FF0;
        dut.RB.MEM[9]  = 32'h00000055;
        dut.RB.MEM[14] = 32'hFFFFFFFF;
        dut.RB.MEM[15] = 32'd10;

        tick();
        tick();
        checkOutput("reset_wb_data", wb_data, 32'h0);
        checkOutput("reset_wb_valid", {31'b0, wb_valid}, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        // ADD r3 = r1 + r2
        applyStimulus(32'h00221820);
        checkOutput("add_alu", alu_result, 32'd8);
        checkOutput("add_zero", {31'b0, zero}, 32'h0);
        tick();
        checkOutput("add_mem3", dut.RB.MEM[3], 32'd8);
        checkOutput("add_wb_data", wb_data, 32'd8);
        checkOutput("add_wb_valid", {31'b0, wb_valid}, 32'h1);

        // SUB r4 = r2 - r1 = -2
        applyStimulus(rtype(5'd2, 5'd1, 5'd4, 6'h22));
        tick();
        checkOutput("sub_mem4", dut.RB.MEM[4], 32'hFFFFFFFE);

        // SLT r5 = (r4 < r1) signed -> 1
        applyStimulus(rtype(5'd4, 5'd1, 5'd5, 6'h2A));
        checkOutput("slt_alu", alu_result, 32'd1);
        tick();
        checkOutput("slt_mem5", dut.RB.MEM[5], 32'd1);

        // SLT r5 = (r1 < r4) signed -> 0
        applyStimulus(rtype(5'd1, 5'd4, 5'd5, 6'h2A));
        checkOutput("slt_rev_alu", alu_result, 32'd0);
        checkOutput("slt_rev_zero", {31'b0, zero}, 32'h1);

        // Logic ops on r6/r7
        applyStimulus(rtype(5'd6, 5'd7, 5'd10, 6'h24));
        checkOutput("and_alu", alu_result, 32'h00F000F0);
        tick();
        checkOutput("and_mem10", dut.RB.MEM[10], 32'h00F000F0);
        applyStimulus(rtype(5'd6, 5'd7, 5'd11, 6'h25));
        checkOutput("or_alu", alu_result, 32'hFFF0FFF0);
        tick();
        checkOutput("or_mem11", dut.RB.MEM[11], 32'hFFF0FFF0);
        applyStimulus(rtype(5'd6, 5'd7, 5'd12, 6'h27));
        checkOutput("nor_alu", alu_result, 32'h000F000F);
        tick();
        checkOutput("nor_mem12", dut.RB.MEM[12], 32'h000F000F);
        checkOutput("nor_wb_data", wb_data, 32'h000F000F);

        // Wrap-around: 0xFFFFFFFF + 5 = 4
        applyStimulus(rtype(5'd14, 5'd1, 5'd13, 6'h20));
        checkOutput("wrap_alu", alu_result, 32'd4);
        tick();
        checkOutput("wrap_mem13", dut.RB.MEM[13], 32'd4);

        // ADD to r0: result visible, write discarded
        applyStimulus(32'h00220020);
        checkOutput("r0_alu", alu_result, 32'd8);
        tick();
        checkOutput("r0_wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("r0_wb_data_held", wb_data, 32'd4);
        applyStimulus(rtype(5'd0, 5'd1, 5'd16, 6'h25));
        checkOutput("r0_read", alu_result, 32'd5);

        // All-zero instruction is a NOP
        applyStimulus(32'h00000000);
        checkOutput("nop_alu", alu_result, 32'h0);
        checkOutput("nop_zero", {31'b0, zero}, 32'h1);
        tick();
        checkOutput("nop_wb_valid", {31'b0, wb_valid}, 32'h0);

        // Non-R-type opcode and unsupported funct are NOPs
        applyStimulus({6'b001000, 5'd1, 5'd2, 5'd17, 5'd0, 6'h20});
        checkOutput("badop_alu", alu_result, 32'h0);
        tick();
        checkOutput("badop_wb_valid", {31'b0, wb_valid}, 32'h0);
        applyStimulus(rtype(5'd1, 5'd2, 5'd17, 6'h21));
        checkOutput("badfunct_alu", alu_result, 32'h0);
        tick();
        checkOutput("badfunct_wb_valid", {31'b0, wb_valid}, 32'h0);

        // Read-during-write: r15 = r15 + r1 twice
        applyStimulus(rtype(5'd15, 5'd1, 5'd15, 6'h20));
        checkOutput("rdw_first_alu", alu_result, 32'd15);
        tick();
        checkOutput("rdw_second_alu", alu_result, 32'd20);
        checkOutput("rdw_mem15", dut.RB.MEM[15], 32'd15);

        // Reset held 2 cycles with a valid ADD r9 = r1 + r2 applied
        @(negedge clk);
        reset       = 1'b1;
        instruction = rtype(5'd1, 5'd2, 5'd9, 6'h20);
        tick();
        tick();
        checkOutput("rst_mem9", dut.RB.MEM[9], 32'h00000055);
        checkOutput("rst_wb_data", wb_data, 32'h0);
        checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("rst_mem1", dut.RB.MEM[1], 32'd5);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back dependency: r3 = r1 + r2, then r8 = r3 + r3
        dut.RB.MEM[3] = 32'h0;
        applyStimulus(32'h00221820);
        applyStimulus(rtype(5'd3, 5'd3, 5'd8, 6'h20));
        checkOutput("dep_alu", alu_result, 32'd16);
        tick();
        checkOutput("dep_mem8", dut.RB.MEM[8], 32'd16);
        checkOutput("dep_wb_data", wb_data, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
